// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// path (req0) and the multicycle/load path (req1); write port is registered.
module wb_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              sel,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   logic              last_grant_q;
   logic              we_q;
   logic              sel_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              arb_en;
   logic              grant0;
   logic              grant1;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // Grants depend only on valids and last_grant, never on data/address.
   assign arb_en = ~hold & ~reset;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (arb_en) begin
         grant0 = req0_valid & (~req1_valid | last_grant_q);
         grant1 = req1_valid & (~req0_valid | ~last_grant_q);
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign win_addr = grant1 ? req1_addr : req0_addr;
   assign win_data = grant1 ? req1_data : req0_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         sel_q        <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
      end else if (!hold) begin
         if (grant0 || grant1) begin
            last_grant_q <= grant1;
            sel_q        <= grant1;
            waddr_q      <= win_addr;
            wdata_q      <= win_data;
            // Writes to register zero are consumed but never enabled.
            we_q         <= (win_addr != '0);
         end else begin
            we_q <= 1'b0;
         end
      end
   end

   // A write held off by hold stays in we_q and appears once hold drops.
   assign rf_we    = we_q & ~hold;
   assign sel      = sel_q;
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter: handshakes, alternation, hold, reset.
module tb_wb_port_arbiter;

   logic        clk;
   logic        reset;
   logic        hold;
   logic        req0_valid;
   logic        req0_ready;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req1_valid;
   logic        req1_ready;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;
   logic        sel;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks;
   int failures;
   logic [31:0] rf_model [32];

   wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .hold(hold),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .sel(sel), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_we) rf_model[rf_waddr] <= rf_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", rf_we); end
      checks++; if (sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", sel); end
      checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
      checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b0;
      tick();
      $display("reset: outputs idle");
   endtask

   task automatic test_req0_only();
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_00AA;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL r0only_ready0 got=%b exp=1", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL r0only_ready1 got=%b exp=0", req1_ready); end
      tick();
      req0_valid = 1'b0;
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL r0only_we got=%b exp=1", rf_we); end
      checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL r0only_waddr got=%0d exp=5", rf_waddr); end
      checks++; if (rf_wdata !== 32'hAA) begin failures++; $display("FAIL r0only_wdata got=%h exp=000000aa", rf_wdata); end
      checks++; if (sel !== 1'b0) begin failures++; $display("FAIL r0only_sel got=%b exp=0", sel); end
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0only_we_drop got=%b exp=0", rf_we); end
      $display("req0_only: addr=5 data=aa written");
   endtask

   task automatic test_zero_write();
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hDEAD_BEEF;
      #1;
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL zero_ready1 got=%b exp=1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL zero_we got=%b exp=0", rf_we); end
      checks++; if (sel !== 1'b1) begin failures++; $display("FAIL zero_sel got=%b exp=1", sel); end
      $display("zero_write: req1 to $zero consumed, not enabled");
   endtask

   task automatic test_alternate();
      logic [4:0] a0;
      logic [4:0] a1;
      logic       exp_g;
      logic [4:0] exp_a;
      a0 = 5'd1;
      a1 = 5'd9;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req0_addr = a0; req0_data = 32'h100 + 32'(a0);
         req1_addr = a1; req1_data = 32'h200 + 32'(a1);
         exp_g = k[0];
         exp_a = exp_g ? a1 : a0;
         #1;
         checks++; if (req0_ready !== ~exp_g) begin failures++; $display("FAIL alt_ready0[%0d] got=%b exp=%b", k, req0_ready, ~exp_g); end
         checks++; if (req1_ready !== exp_g) begin failures++; $display("FAIL alt_ready1[%0d] got=%b exp=%b", k, req1_ready, exp_g); end
         tick();
         checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alt_we[%0d] got=%b exp=1", k, rf_we); end
         checks++; if (sel !== exp_g) begin failures++; $display("FAIL alt_sel[%0d] got=%b exp=%b", k, sel, exp_g); end
         checks++; if (rf_waddr !== exp_a) begin failures++; $display("FAIL alt_waddr[%0d] got=%0d exp=%0d", k, rf_waddr, exp_a); end
         $display("alternate[%0d]: grant=%0d waddr=%0d", k, exp_g, rf_waddr);
         if (exp_g) a1 = a1 + 5'd1;
         else       a0 = a0 + 5'd1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_hold();
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1234;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL hold_accept got=%b exp=1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      hold = 1'b1;
      req1_valid = 1'b1; req1_addr = 5'd15; req1_data = 32'h5555;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL hold_we[%0d] got=%b exp=0", k, rf_we); end
         checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL hold_ready1[%0d] got=%b exp=0", k, req1_ready); end
         tick();
      end
      hold = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL hold_release_we got=%b exp=1", rf_we); end
      checks++; if (rf_waddr !== 5'd7) begin failures++; $display("FAIL hold_release_waddr got=%0d exp=7", rf_waddr); end
      checks++; if (rf_wdata !== 32'h1234) begin failures++; $display("FAIL hold_release_wdata got=%h exp=00001234", rf_wdata); end
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready1 got=%b exp=1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL hold_next_we got=%b exp=1", rf_we); end
      checks++; if (rf_waddr !== 5'd15) begin failures++; $display("FAIL hold_next_waddr got=%0d exp=15", rf_waddr); end
      checks++; if (rf_wdata !== 32'h5555) begin failures++; $display("FAIL hold_next_wdata got=%h exp=00005555", rf_wdata); end
      checks++; if (rf_model[7] !== 32'h1234) begin failures++; $display("FAIL hold_rf7 got=%h exp=00001234", rf_model[7]); end
      tick();
      $display("hold: suppressed write to 7 then req1 write to 15");
   endtask

   task automatic test_same_addr();
      req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h22;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL same_ready0 got=%b exp=1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      checks++; if (rf_wdata !== 32'h11) begin failures++; $display("FAIL same_first_wdata got=%h exp=00000011", rf_wdata); end
      checks++; if (sel !== 1'b0) begin failures++; $display("FAIL same_first_sel got=%b exp=0", sel); end
      #1;
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL same_ready1 got=%b exp=1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      checks++; if (rf_wdata !== 32'h22) begin failures++; $display("FAIL same_second_wdata got=%h exp=00000022", rf_wdata); end
      checks++; if (sel !== 1'b1) begin failures++; $display("FAIL same_second_sel got=%b exp=1", sel); end
      tick();
      checks++; if (rf_model[8] !== 32'h22) begin failures++; $display("FAIL same_rf8 got=%h exp=00000022", rf_model[8]); end
      $display("same_addr: RF[8]=%h", rf_model[8]);
   endtask

   task automatic test_drop_valid();
      hold = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
      tick();
      req0_valid = 1'b0;
      hold = 1'b0;
      #1;
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL drop_ready0 got=%b exp=0", req0_ready); end
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL drop_we got=%b exp=0", rf_we); end
      checks++; if (rf_waddr !== 5'd8) begin failures++; $display("FAIL drop_waddr got=%0d exp=8", rf_waddr); end
      $display("drop_valid: no grant, state unchanged");
   endtask

   task automatic test_reset_mid();
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h77;
      tick();
      req0_valid = 1'b0;
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL rmid_pre_we got=%b exp=1", rf_we); end
      hold = 1'b1;
      reset = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_addr = 5'd2; req1_addr = 5'd6;
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%b%b exp=00", req0_ready, req1_ready); end
      tick();
      hold = 1'b0;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rmid_we got=%b exp=0", rf_we); end
      checks++; if (sel !== 1'b0) begin failures++; $display("FAIL rmid_sel got=%b exp=0", sel); end
      checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL rmid_waddr got=%0d exp=0", rf_waddr); end
      checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL rmid_wdata got=%h exp=0", rf_wdata); end
      reset = 1'b0;
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rmid_tie_ready0 got=%b exp=1", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL rmid_tie_ready1 got=%b exp=0", req1_ready); end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++; if (rf_waddr !== 5'd2) begin failures++; $display("FAIL rmid_tie_waddr got=%0d exp=2", rf_waddr); end
      tick();
      $display("reset_mid: pending write discarded, tie to req0");
   endtask

   initial begin
      checks = 0;
      failures = 0;
      for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
      reset = 1'b1; hold = 1'b0;
      req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
      req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
      tick();
      tick();
      test_reset();
      test_req0_only();
      test_zero_write();
      test_alternate();
      test_hold();
      test_same_addr();
      test_drop_valid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Never two readies in one cycle.
   always @(negedge clk) begin
      if (req0_ready && req1_ready) begin
         failures++;
         $display("FAIL both_ready got=11 exp=not both");
      end
   end

endmodule
